// File: rtl/port_ring_tap_mc.sv
// Ring tap for the bridge: forwards, delivers locally or multicasts ring
// packets according to the port-enable vector in the header word, and
// injects local receive packets onto the ring. All handshakes are
// combinational pass-through; only the packet state, the arbitration
// history and the protocol-error pulse are registered.
module port_ring_tap_mc #(
    parameter int rdp_sz        = 64,
    parameter int num_ports     = 4,
    parameter int portnum       = 0,
    parameter int ring_priority = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lri_srdy,
    input  logic [1:0]        lri_code,
    input  logic [rdp_sz-1:0] lri_data,
    output logic              lri_drdy,
    output logic              lro_srdy,
    output logic [1:0]        lro_code,
    output logic [rdp_sz-1:0] lro_data,
    input  logic              lro_drdy,
    input  logic              lprx_srdy,
    input  logic [1:0]        lprx_code,
    input  logic [rdp_sz-1:0] lprx_data,
    output logic              lprx_drdy,
    output logic              lptx_srdy,
    output logic [1:0]        lptx_code,
    output logic [rdp_sz-1:0] lptx_data,
    input  logic              lptx_drdy,
    output logic              proto_err
);

    localparam logic [1:0] code_data = 2'b00;
    localparam logic [1:0] code_hdr  = 2'b01;
    localparam logic [1:0] code_eop  = 2'b10;
    localparam logic [1:0] code_rsv  = 2'b11;

    localparam logic [num_ports-1:0] port_mask   = num_ports'(1'b1) << portnum;
    localparam logic [rdp_sz-1:0]    port_mask_w = rdp_sz'(port_mask);
    localparam logic [num_ports-1:0] zero_v      = {num_ports{1'b0}};
    localparam logic                 ring_first  = (ring_priority != 32'sd0);

    typedef enum logic [5:0] {
        s_idle  = 6'b000001,
        s_rfwd  = 6'b000010,
        s_rcopy = 6'b000100,
        s_rsink = 6'b001000,
        s_tdata = 6'b010000,
        s_tdrop = 6'b100000
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 last_local_r;
    logic                 last_local_nxt_s;
    logic                 proto_err_r;
    logic                 err_s;
    logic                 ring_pend_s;
    logic                 local_pend_s;
    logic                 serve_ring_s;
    logic [num_ports-1:0] ring_v_s;
    logic [num_ports-1:0] local_v_s;
    logic                 data_xfer_s;
    logic [1:0]           data_code_s;

    // Mid-packet words are always emitted as data or end-of-packet, never as a header.
    function automatic logic [1:0] pass_code(input logic [1:0] code);
        logic [1:0] res;
        if (code == code_eop) begin
            res = code_eop;
        end else begin
            res = code_data;
        end
        return res;
    endfunction

    assign proto_err = proto_err_r;

    // Idle-time arbitration terms between a pending ring header and a pending local header.
    always_comb begin
        ring_v_s     = lri_data[num_ports-1:0];
        local_v_s    = lprx_data[num_ports-1:0] & ~port_mask;
        ring_pend_s  = lri_srdy & (lri_code == code_hdr);
        local_pend_s = lprx_srdy & (lprx_code == code_hdr);
        serve_ring_s = ring_pend_s & (ring_first | ~local_pend_s | last_local_r);
    end

    // Next-state, handshake steering and output muxing; everything is closed during reset.
    always_comb begin
        lri_drdy         = 1'b0;
        lro_srdy         = 1'b0;
        lro_code         = lri_code;
        lro_data         = lri_data;
        lprx_drdy        = 1'b0;
        lptx_srdy        = 1'b0;
        lptx_code        = pass_code(lri_code);
        lptx_data        = lri_data;
        state_nxt_s      = state_r;
        last_local_nxt_s = last_local_r;
        err_s            = 1'b0;
        data_xfer_s      = 1'b0;
        data_code_s      = code_data;
        if (reset) begin
            state_nxt_s      = s_idle;
            last_local_nxt_s = 1'b0;
        end else begin
            case (state_r)
                s_idle: begin
                    if (serve_ring_s) begin
                        if ((ring_v_s & port_mask) == zero_v) begin
                            lro_srdy = 1'b1;
                            lri_drdy = lro_drdy;
                            if (lro_drdy) begin
                                state_nxt_s      = s_rfwd;
                                last_local_nxt_s = 1'b0;
                            end else begin
                                state_nxt_s = s_idle;
                            end
                        end else if (ring_v_s != port_mask) begin
                            lro_srdy = 1'b1;
                            lro_data = lri_data & ~port_mask_w;
                            lri_drdy = lro_drdy;
                            if (lro_drdy) begin
                                state_nxt_s      = s_rcopy;
                                last_local_nxt_s = 1'b0;
                            end else begin
                                state_nxt_s = s_idle;
                            end
                        end else begin
                            lri_drdy         = 1'b1;
                            state_nxt_s      = s_rsink;
                            last_local_nxt_s = 1'b0;
                        end
                    end else begin
                        // A stray ring data word is discarded unless a ring header is waiting.
                        if (lri_srdy && (lri_code != code_hdr)) begin
                            lri_drdy = 1'b1;
                            err_s    = 1'b1;
                        end else begin
                            lri_drdy = 1'b0;
                        end
                        if (local_pend_s) begin
                            if (local_v_s != zero_v) begin
                                lro_srdy  = 1'b1;
                                lro_code  = code_hdr;
                                lro_data  = lprx_data & ~port_mask_w;
                                lprx_drdy = lro_drdy;
                                if (lro_drdy) begin
                                    state_nxt_s      = s_tdata;
                                    last_local_nxt_s = 1'b1;
                                end else begin
                                    state_nxt_s = s_idle;
                                end
                            end else begin
                                lprx_drdy        = 1'b1;
                                state_nxt_s      = s_tdrop;
                                last_local_nxt_s = 1'b1;
                            end
                        end else if (lprx_srdy) begin
                            lprx_drdy = 1'b1;
                            err_s     = 1'b1;
                        end else begin
                            lprx_drdy = 1'b0;
                        end
                    end
                end
                s_rfwd: begin
                    lro_srdy    = lri_srdy;
                    lro_code    = pass_code(lri_code);
                    lri_drdy    = lro_drdy;
                    data_xfer_s = lri_srdy & lro_drdy;
                    data_code_s = lri_code;
                end
                s_rcopy: begin
                    // Fork: a word leaves on both outputs in the same cycle or not at all.
                    lro_srdy    = lri_srdy & lptx_drdy;
                    lro_code    = pass_code(lri_code);
                    lptx_srdy   = lri_srdy & lro_drdy;
                    lri_drdy    = lro_drdy & lptx_drdy;
                    data_xfer_s = lri_srdy & lro_drdy & lptx_drdy;
                    data_code_s = lri_code;
                end
                s_rsink: begin
                    lptx_srdy   = lri_srdy;
                    lri_drdy    = lptx_drdy;
                    data_xfer_s = lri_srdy & lptx_drdy;
                    data_code_s = lri_code;
                end
                s_tdata: begin
                    lro_srdy    = lprx_srdy;
                    lro_code    = pass_code(lprx_code);
                    lro_data    = lprx_data;
                    lprx_drdy   = lro_drdy;
                    data_xfer_s = lprx_srdy & lro_drdy;
                    data_code_s = lprx_code;
                end
                s_tdrop: begin
                    lprx_drdy   = 1'b1;
                    data_xfer_s = lprx_srdy;
                    data_code_s = lprx_code;
                end
                default: begin
                    state_nxt_s = s_idle;
                end
            endcase
        end
        // Packet end and mid-packet code violations, common to every data state.
        if (data_xfer_s) begin
            if (data_code_s == code_eop) begin
                state_nxt_s = s_idle;
            end else if ((data_code_s == code_hdr) || (data_code_s == code_rsv)) begin
                err_s = 1'b1;
            end else begin
                err_s = 1'b0;
            end
        end else begin
            data_code_s = data_code_s;
        end
    end

    // State, arbitration history and error pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= s_idle;
            last_local_r <= 1'b0;
            proto_err_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            last_local_r <= last_local_nxt_s;
            proto_err_r  <= err_s;
        end
    end

endmodule

// File: tb/tb_port_ring_tap_mc.sv
// Scoreboard bench for port_ring_tap_mc (portnum=1, num_ports=4). Expected
// ring-out and local-transmit words are derived per packet from the header
// vector and queued; a negedge monitor pops them on every output transfer.
module tb_port_ring_tap_mc;
    localparam int W  = 64;
    localparam int NP = 4;
    localparam int PN = 1;
    localparam int RP = 0;
    localparam logic [W-1:0] MASK_W = 64'h2;
    localparam logic [3:0]   MASK_V = 4'b0010;

    logic         clk = 1'b0;
    logic         reset;
    logic         lri_srdy, lri_drdy, lro_srdy, lro_drdy;
    logic [1:0]   lri_code, lro_code, lprx_code, lptx_code;
    logic [W-1:0] lri_data, lro_data, lprx_data, lptx_data;
    logic         lprx_srdy, lprx_drdy, lptx_srdy, lptx_drdy, proto_err;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          err_seen = 0;
    bit          rand_drdy = 1'b0;
    bit          ll_m = 1'b0;
    logic [65:0] exp_lro[$];
    logic [65:0] exp_lptx[$];
    logic [65:0] ring_stream[$];
    logic [65:0] local_stream[$];

    always #5 clk = ~clk;

    port_ring_tap_mc #(.rdp_sz(W), .num_ports(NP), .portnum(PN), .ring_priority(RP)) dut (
        .clk(clk), .reset(reset),
        .lri_srdy(lri_srdy), .lri_code(lri_code), .lri_data(lri_data), .lri_drdy(lri_drdy),
        .lro_srdy(lro_srdy), .lro_code(lro_code), .lro_data(lro_data), .lro_drdy(lro_drdy),
        .lprx_srdy(lprx_srdy), .lprx_code(lprx_code), .lprx_data(lprx_data), .lprx_drdy(lprx_drdy),
        .lptx_srdy(lptx_srdy), .lptx_code(lptx_code), .lptx_data(lptx_data), .lptx_drdy(lptx_drdy),
        .proto_err(proto_err)
    );

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Ring packet: forwarded if our bit is clear, sunk if only our bit, else copied with our bit cleared.
    task automatic gen_ring(input int vsel);
        logic [3:0]  v;
        logic [63:0] h, d;
        logic [1:0]  c;
        int          n;
        bit          fwd, copy;
        v = (vsel < 0) ? 4'($urandom_range(0, 15)) : 4'(vsel);
        h = rnd64();
        h[3:0] = v;
        ring_stream.push_back({2'b01, h});
        fwd  = (v != MASK_V);
        copy = ((v & MASK_V) != 4'b0000);
        if (fwd) exp_lro.push_back({2'b01, copy ? (h & ~MASK_W) : h});
        n = $urandom_range(0, 3);
        for (int i = 0; i <= n; i++) begin
            d = rnd64();
            c = (i == n) ? 2'b10 : 2'b00;
            ring_stream.push_back({c, d});
            if (fwd)  exp_lro.push_back({c, d});
            if (copy) exp_lptx.push_back({c, d});
        end
        ll_m = 1'b0;
    endtask

    // Local packet: injected with our bit cleared, or dropped when no other port remains.
    task automatic gen_local(input int vsel);
        logic [3:0]  v;
        logic [63:0] h, d;
        logic [1:0]  c;
        int          n;
        bit          keep;
        v = (vsel < 0) ? 4'($urandom_range(0, 15)) : 4'(vsel);
        h = rnd64();
        h[3:0] = v;
        local_stream.push_back({2'b01, h});
        keep = ((v & ~MASK_V) != 4'b0000);
        if (keep) exp_lro.push_back({2'b01, h & ~MASK_W});
        n = $urandom_range(0, 3);
        for (int i = 0; i <= n; i++) begin
            d = rnd64();
            c = (i == n) ? 2'b10 : 2'b00;
            local_stream.push_back({c, d});
            if (keep) exp_lro.push_back({c, d});
        end
        ll_m = 1'b1;
    endtask

    // Streams queued ring words with optional idle gaps; starts and ends just after a posedge.
    task automatic drive_ring(input int gap_max);
        logic [65:0] w;
        bit          ok;
        int          t;
        while (ring_stream.size() > 0) begin
            w = ring_stream.pop_front();
            repeat ($urandom_range(0, gap_max)) begin
                lri_srdy = 1'b0;
                lri_code = 2'($urandom);
                lri_data = rnd64();
                @(posedge clk); #1;
            end
            lri_srdy = 1'b1;
            lri_code = w[65:64];
            lri_data = w[63:0];
            t = 0;
            do begin
                @(negedge clk);
                ok = lri_drdy;
                @(posedge clk); #1;
                t++;
            end while (!ok && t < 500);
            if (!ok) begin
                n_checks++;
                n_fail++;
                $display("FAIL ring_timeout: got no accept expected accept within 500 cycles");
                ring_stream.delete();
            end
        end
        lri_srdy = 1'b0;
    endtask

    // Streams queued local-receive words with optional idle gaps.
    task automatic drive_local(input int gap_max);
        logic [65:0] w;
        bit          ok;
        int          t;
        while (local_stream.size() > 0) begin
            w = local_stream.pop_front();
            repeat ($urandom_range(0, gap_max)) begin
                lprx_srdy = 1'b0;
                lprx_code = 2'($urandom);
                lprx_data = rnd64();
                @(posedge clk); #1;
            end
            lprx_srdy = 1'b1;
            lprx_code = w[65:64];
            lprx_data = w[63:0];
            t = 0;
            do begin
                @(negedge clk);
                ok = lprx_drdy;
                @(posedge clk); #1;
                t++;
            end while (!ok && t < 500);
            if (!ok) begin
                n_checks++;
                n_fail++;
                $display("FAIL local_timeout: got no accept expected accept within 500 cycles");
                local_stream.delete();
            end
        end
        lprx_srdy = 1'b0;
    endtask

    // Random downstream back-pressure.
    always begin
        @(posedge clk); #1;
        if (rand_drdy) begin
            lro_drdy  = ($urandom_range(0, 3) != 0);
            lptx_drdy = ($urandom_range(0, 3) != 0);
        end
    end

    // Scoreboard monitor: compares every output transfer against the queued expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (proto_err) err_seen++;
            if (lro_srdy && lro_drdy) begin
                if (exp_lro.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL lro_unexpected: got %h expected no word", {lro_code, lro_data});
                end else begin
                    check("lro_word", {lro_code, lro_data}, exp_lro.pop_front());
                end
            end
            if (lptx_srdy && lptx_drdy) begin
                if (exp_lptx.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL lptx_unexpected: got %h expected no word", {lptx_code, lptx_data});
                end else begin
                    check("lptx_word", {lptx_code, lptx_data}, exp_lptx.pop_front());
                end
            end
        end
    end

    initial begin
        int          nr, nl;
        logic [63:0] h, d;
        reset = 1'b1;
        lri_srdy = 1'b1; lri_code = 2'b01; lri_data = 64'h4;
        lprx_srdy = 1'b1; lprx_code = 2'b01; lprx_data = 64'h8;
        lro_drdy = 1'b1; lptx_drdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outs", {lri_drdy, lro_srdy, lprx_drdy, lptx_srdy, proto_err}, 5'b00000);
        @(posedge clk); #1;
        reset = 1'b0;
        lri_srdy = 1'b0;
        lprx_srdy = 1'b0;
        rand_drdy = 1'b1;

        // Ring-only traffic, including forced forward / copy / sink headers.
        gen_ring(4'b0100);
        gen_ring(4'b0110);
        gen_ring(4'b0010);
        repeat (12) gen_ring(-1);
        drive_ring(2);

        // Local-only traffic, including forced inject / drop headers.
        gen_local(4'b1010);
        gen_local(4'b0010);
        repeat (12) gen_local(-1);
        drive_local(2);

        // Both sides continuously pending at every packet boundary.
        nr = 8;
        nl = 8;
        while (nr > 0 || nl > 0) begin
            if (nr > 0 && (RP != 0 || nl == 0 || ll_m)) begin
                gen_ring(-1);
                nr--;
            end else begin
                gen_local(-1);
                nl--;
            end
        end
        fork
            drive_ring(0);
            drive_local(0);
        join
        repeat (2) @(posedge clk);
        #1;
        check("lro_drained", 66'(exp_lro.size()), 66'd0);
        check("lptx_drained", 66'(exp_lptx.size()), 66'd0);
        check("no_proto_err", 66'(err_seen), 66'd0);

        // Stray data word in idle: consumed, dropped, one-cycle error pulse.
        rand_drdy = 1'b0;
        lro_drdy = 1'b1;
        lptx_drdy = 1'b1;
        lri_srdy = 1'b1; lri_code = 2'b00; lri_data = rnd64();
        @(negedge clk);
        check("drop_accept", {lri_drdy, lro_srdy, lptx_srdy, proto_err}, 4'b1000);
        @(posedge clk); #1;
        lri_srdy = 1'b0;
        @(negedge clk);
        check("perr_pulse", proto_err, 1'b1);
        @(negedge clk);
        check("perr_clear", proto_err, 1'b0);
        @(posedge clk); #1;

        // Reset in the middle of a multicast copy.
        h = rnd64();
        h[3:0] = 4'b0110;
        d = rnd64();
        ring_stream.push_back({2'b01, h});
        ring_stream.push_back({2'b00, d});
        exp_lro.push_back({2'b01, h & ~MASK_W});
        exp_lro.push_back({2'b00, d});
        exp_lptx.push_back({2'b00, d});
        drive_ring(0);
        reset = 1'b1;
        lri_srdy = 1'b1; lri_code = 2'b10; lri_data = rnd64();
        lprx_srdy = 1'b1; lprx_code = 2'b01; lprx_data = rnd64();
        @(negedge clk);
        check("rst_handshakes", {lri_drdy, lro_srdy, lprx_drdy, lptx_srdy}, 4'b0000);
        @(posedge clk); #1;
        reset = 1'b0;
        lprx_srdy = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {lri_drdy, lro_srdy, lptx_srdy}, 3'b100);
        @(posedge clk); #1;
        lri_srdy = 1'b0;
        @(negedge clk);
        check("post_rst_perr", proto_err, 1'b1);
        check("final_lro_empty", 66'(exp_lro.size()), 66'd0);
        check("final_lptx_empty", 66'(exp_lptx.size()), 66'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
